// File: rtl/imm_extend_stage_pkg.sv
// Shared constants for the LEGv8 immediate-extend stage: widths, format codes
// and the opcode fields used to classify an instruction.
package imm_extend_stage_pkg;

  localparam int INSTR_LEN = 32;
  localparam int WORD      = 64;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_D   = 3'd1,
    FMT_I   = 3'd2,
    FMT_IW  = 3'd3,
    FMT_CB  = 3'd4,
    FMT_B   = 3'd5,
    FMT_UNK = 3'd7
  } imm_fmt_e;

  // Opcode fields, each compared against the top bits of the instruction.
  localparam logic [5:0]  OP_B    = 6'h05;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;
  localparam logic [8:0]  OP_MOVZ = 9'h1A5;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;

endpackage

// File: rtl/imm_extend_stage_decode.sv
// Combinational instruction classifier and immediate extractor.
// IMM_BR_SCALE_EN: when defined, B and CB immediates become byte offsets (<< 2).
module imm_decode
  import imm_extend_stage_pkg::*;
#(
  parameter int WORD_W  = WORD,
  parameter int INSTR_W = INSTR_LEN
) (
  input  logic [INSTR_W-1:0] instruction,
  output logic [WORD_W-1:0]  imm,
  output imm_fmt_e           fmt
);

`ifdef IMM_BR_SCALE_EN
  localparam int BR_SHIFT = 2;
`else
  localparam int BR_SHIFT = 0;
`endif

  logic [10:0] op11;
  assign op11 = instruction[31:21];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    imm = '0;
    fmt = FMT_UNK;
    if (instruction[31:26] == OP_B) begin
      fmt = FMT_B;
      imm = {{(WORD_W-26){instruction[25]}}, instruction[25:0]} << BR_SHIFT;
    end else if (instruction[31:24] == OP_CBZ || instruction[31:24] == OP_CBNZ) begin
      fmt = FMT_CB;
      imm = {{(WORD_W-19){instruction[23]}}, instruction[23:5]} << BR_SHIFT;
    end else if (instruction[31:23] == OP_MOVZ) begin
      fmt = FMT_IW;
      imm = {{(WORD_W-16){1'b0}}, instruction[20:5]} << {instruction[22:21], 4'b0000};
    end else if (instruction[31:22] == OP_ADDI || instruction[31:22] == OP_SUBI) begin
      fmt = FMT_I;
      imm = {{(WORD_W-12){1'b0}}, instruction[21:10]};
    end else if (op11 == OP_LDUR || op11 == OP_STUR) begin
      fmt = FMT_D;
      imm = {{(WORD_W-9){instruction[20]}}, instruction[20:12]};
    end else if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND || op11 == OP_ORR) begin
      fmt = FMT_R;
    end
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Decode-stage immediate generator with a DEPTH-entry output FIFO and
// valid/ready handshakes. Branch scaling is selected by IMM_BR_SCALE_EN.
module imm_extend_stage
  import imm_extend_stage_pkg::*;
#(
  parameter int WORD_W  = WORD,
  parameter int INSTR_W = INSTR_LEN,
  parameter int DEPTH   = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Flush,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic [INSTR_W-1:0]         Instruction,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [WORD_W-1:0]          Sign_Extended,
  output logic [2:0]                 Imm_Fmt,
  output logic [INSTR_W-1:0]         Instr_Out,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0]  imm_mem   [DEPTH];
  logic [2:0]         fmt_mem   [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic [WORD_W-1:0] dec_imm;
  imm_fmt_e          dec_fmt;
  logic              do_write, do_read;

  imm_decode #(
    .WORD_W  (WORD_W),
    .INSTR_W (INSTR_W)
  ) u_decode (
    .instruction (Instruction),
    .imm         (dec_imm),
    .fmt         (dec_fmt)
  );

  // Handshake flags depend only on registered occupancy, never on Out_Ready.
  assign In_Ready  = (cnt != CNT_W'(DEPTH));
  assign Out_Valid = (cnt != '0);
  assign do_write  = In_Valid && In_Ready && !Flush;
  assign do_read   = Out_Valid && Out_Ready && !Flush;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      // NOTE: storage is reset only so simulation shows no X; correctness relies on cnt alone.
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem[i]   <= '0;
        fmt_mem[i]   <= '0;
        instr_mem[i] <= '0;
      end
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (do_write) begin
        imm_mem[wr_ptr]   <= dec_imm;
        fmt_mem[wr_ptr]   <= dec_fmt;
        instr_mem[wr_ptr] <= Instruction;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_write, do_read})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign Sign_Extended = imm_mem[rd_ptr];
  assign Imm_Fmt       = fmt_mem[rd_ptr];
  assign Instr_Out     = instr_mem[rd_ptr];
  assign Count         = cnt;

endmodule
